// File: rtl/arb_pkg.sv
// Shared types, constants and helpers for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int NREQ_C = 8;
  localparam int IDXW   = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  // Next index in round-robin order, wrapping 7 -> 0.
  function automatic logic [IDXW-1:0] rot_next(input logic [IDXW-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: the first set bit of cand, searching
// upward from ptr and wrapping, is returned as a one-hot vector and an index.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ_C-1:0] cand,
  input  logic [IDXW-1:0]   ptr,
  output logic [NREQ_C-1:0] pick_oh,
  output logic [IDXW-1:0]   pick_idx,
  output logic              any
);

  logic [NREQ_C-1:0] rot;
  logic [IDXW-1:0]   off;

  // Rotate so that bit 0 of rot is requester ptr, then find the lowest set bit.
  always_comb begin
    rot = NREQ_C'({cand, cand} >> ptr);
    off = '0;
    for (int i = NREQ_C - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = i[IDXW-1:0];
      end
    end
    any      = |cand;
    pick_idx = ptr + off;
    pick_oh  = '0;
    if (any) begin
      pick_oh[pick_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with grant locking and a bounded
// hold time. All outputs are registered; gnt is one-hot or zero.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int NREQ     = 8,
  parameter int MAX_HOLD = 16,
  parameter int HCW      = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic            preempt
);

  arb_state_t        state_reg, state_next;
  logic [IDXW-1:0]   ptr_reg, ptr_next;
  logic [IDXW-1:0]   owner_reg, owner_next;
  logic [HCW-1:0]    cnt_reg, cnt_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic              valid_reg;
  logic              preempt_reg, preempt_next;

  logic [NREQ-1:0]   cand;
  logic [NREQ-1:0]   pick_oh;
  logic [IDXW-1:0]   pick_idx;
  logic              pick_any;
  logic              owner_req;
  logic              hold_hit;

  // Candidates: everything when idle, everyone but the owner when owned.
  always_comb begin
    cand = (state_reg == ARB_IDLE) ? req : (req & ~gnt_reg);
  end

  rr_pick u_pick (
    .cand     (cand),
    .ptr      (ptr_reg),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  assign owner_req = req[owner_reg];
  assign hold_hit  = (MAX_HOLD != 0) && (cnt_reg == HCW'(MAX_HOLD - 1));

  // Next-state: grant, hold, release/handover, preemption on hold expiry.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    owner_next   = owner_reg;
    cnt_next     = cnt_reg;
    gnt_next     = gnt_reg;
    preempt_next = 1'b0;

    case (state_reg)
      ARB_IDLE: begin
        if (pick_any) begin
          state_next = ARB_OWNED;
          gnt_next   = pick_oh;
          owner_next = pick_idx;
          ptr_next   = rot_next(pick_idx);
          cnt_next   = '0;
        end
      end
      ARB_OWNED: begin
        if (!owner_req) begin
          // Release takes precedence over hold expiry; hand over with no bubble.
          if (pick_any) begin
            gnt_next   = pick_oh;
            owner_next = pick_idx;
            ptr_next   = rot_next(pick_idx);
            cnt_next   = '0;
          end else begin
            state_next = ARB_IDLE;
            gnt_next   = '0;
            cnt_next   = '0;
          end
        end else if (hold_hit) begin
          // Hold expired: preempt only if someone else is waiting, else saturate.
          if (pick_any) begin
            gnt_next     = pick_oh;
            owner_next   = pick_idx;
            ptr_next     = rot_next(pick_idx);
            cnt_next     = '0;
            preempt_next = 1'b1;
          end
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ARB_IDLE;
      ptr_reg     <= '0;
      owner_reg   <= '0;
      cnt_reg     <= '0;
      gnt_reg     <= '0;
      valid_reg   <= 1'b0;
      preempt_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      owner_reg   <= owner_next;
      cnt_reg     <= cnt_next;
      gnt_reg     <= gnt_next;
      valid_reg   <= |gnt_next;
      preempt_reg <= preempt_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = valid_reg;
  assign preempt   = preempt_reg;

endmodule
